pwm_multi_gen: RTL
==================

Name: pwm_multi_gen

Overview:
N-channel PWM generator with per-channel debounced increase/decrease buttons and saturating duty steps. Duty and mode changes take effect only at period boundaries, so output pulses are never truncated. Supports edge-aligned and center-aligned (triangle) modes. Successor to the single-channel fixed 10-step PWM block; serves LED/motor drive channels.

Parameters:
N_CH, 4, number of independent PWM channels
CNT_W, 8, width of the period counter and duty registers
PERIOD, 100, counts per edge-aligned period; legal range 2..2^CNT_W-1
STEP, 10, duty change per accepted button press; must be >=1
DUTY_INIT, 50, reset duty for every channel; must be <=PERIOD
DEB_DIV, 4, slow-enable divisor for button sampling; must be >=2

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
inc  in  N_CH  per-channel increase button (asynchronous, bouncy)
dec  in  N_CH  per-channel decrease button (asynchronous, bouncy)
mode  in  1  0 = edge-aligned, 1 = center-aligned; sampled at period start
duty_o  out  N_CH*CNT_W  per-channel pending duty register, ch0 in LSBs
pwm_out  out  N_CH  registered PWM outputs
period_start  out  1  one-cycle pulse on the first cycle of each period

Behaviour:
- Reset only on posedge clk with rst=1. All state is cleared; reset asserted mid-period aborts the period immediately.
- Reset values:
  - deb_cnt=0; button sync stages=0; cnt=0; dir=up.
  - duty_reg=duty_act=DUTY_INIT for all channels; mode_act=0.
  - pwm_out=0; period_start=0.
- Slow enable:
  - deb_cnt counts 0..DEB_DIV-1 and wraps.
  - slow_en=1 for the single cycle where deb_cnt==DEB_DIV-1.
- Debounce, per button:
  - s1<=button and s2<=s1, both only when slow_en=1.
  - press pulse = s1 & ~s2 & slow_en.
  - One pulse per press. Holding the button gives no repeat. A glitch shorter than one slow_en interval is rejected unless it coincides with a sample.
- Duty update, per channel, on press pulse:
  - inc only: duty_reg <= min(duty_reg+STEP, PERIOD), computed at CNT_W+1 bits, no wrap.
  - dec only: duty_reg <= max(duty_reg-STEP, 0), no underflow.
  - inc and dec pulse in the same cycle: no change.
  - duty_o shows duty_reg the cycle after the update.
- Period counter, edge mode (mode_act=0):
  - cnt 0..PERIOD-1, wraps to 0.
  - Period length is PERIOD cycles.
- Period counter, center mode (mode_act=1):
  - cnt counts up 0..PERIOD-1, then down PERIOD-1..0; each endpoint is held for one cycle.
  - Period length is 2*PERIOD cycles. Period start is cnt=0 with dir=up.
- Boundary load:
  - On the clock edge that begins a new period: duty_act<=duty_reg for all channels, mode_act<=mode, cnt<=0, dir<=up.
  - period_start=1 during that first cycle.
  - The first period after reset starts at the cycle after rst deasserts; period_start=1 in that cycle.
  - A mode change mid-period is ignored until the boundary; the counter then restarts cleanly at 0.
- Compare (registered):
  - Each cycle, pwm_out is the compare result of the previous cycle's counter and duty_act (1-cycle latency).
  - Edge mode: compare = cnt < duty_act.
  - Center mode: compare = cnt >= PERIOD-duty_act.
  - duty=0 gives constant 0; duty=PERIOD gives constant 1 in both modes.
  - High time per period: edge mode = duty_act cycles; center mode = 2*duty_act cycles, centered on the counter peak.

Test Plan:
- Reset/default: defaults, release rst, edge mode -> period_start every 100 cycles; each pwm_out high 50 of 100 cycles (lags the counter by 1 cycle); duty_o all 50.
- Single press: inc[0] held high for 20 cycles -> exactly one pulse; duty_o[7:0]=60; pwm_out[0] still high 50 cycles until the next period_start, then 60; other channels unchanged at 50.
- Saturation: 7 presses inc[1] -> duty 60,70,80,90,100,100,100; pwm_out[1] constant 1. Then 11 presses dec[1] -> duty reaches 0, stays 0; pwm_out[1] constant 0.
- Simultaneous and hold: inc[2] and dec[2] rise on the same cycle -> duty_o[23:16] stays 50. inc[3] held high for 500 cycles -> single increment to 60.
- Center mode: set mode=1 mid-period -> change applies at the next boundary. Then period is 200 cycles; duty 50 gives pwm high 100 cycles, covering cnt>=50 on both up and down ramps, symmetric about the peak.
- Reset mid-operation: duty_o[7:0]=80 and cnt=37; assert rst for 1 cycle -> duty 50, pwm_out=0, counter restarts at 0, and period_start fires the cycle after reset.

Source files
------------

// File: rtl/pwm_multi_gen.sv
// pwm_multi_gen: N-channel PWM with debounced inc/dec buttons per channel.
// Duty and mode load only at period boundaries; edge or center aligned.
module pwm_multi_gen #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 8,
  parameter int PERIOD    = 100,
  parameter int STEP      = 10,
  parameter int DUTY_INIT = 50,
  parameter int DEB_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       inc,
  input  logic [N_CH-1:0]       dec,
  input  logic                  mode,
  output logic [N_CH*CNT_W-1:0] duty_o,
  output logic [N_CH-1:0]       pwm_out,
  output logic                  period_start
);

  localparam int DW = (DEB_DIV > 2) ? $clog2(DEB_DIV) : 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PER_C = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_INIT);
  localparam logic [CNT_W:0] PER_X = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0] STEP_X = (CNT_W+1)'(STEP);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_UP,
    ST_DOWN
  } state_e;

  // Slow sampling enable
  logic [DW-1:0] deb_cnt_q;
  logic [DW-1:0] deb_cnt_d;
  logic          slow_en;

  always_comb begin
    slow_en   = (deb_cnt_q == DEB_LAST);
    deb_cnt_d = slow_en ? '0 : deb_cnt_q + DW'(1);
  end

  // Button sampling; inc in the low half, dec in the high half
  logic [2*N_CH-1:0] btn;
  logic [2*N_CH-1:0] s1_q;
  logic [2*N_CH-1:0] s1_d;
  logic [2*N_CH-1:0] s2_q;
  logic [2*N_CH-1:0] s2_d;
  logic [2*N_CH-1:0] press;

  assign btn = {dec, inc};

  always_comb begin
    s1_d  = slow_en ? btn  : s1_q;
    s2_d  = slow_en ? s1_q : s2_q;
    press = s1_q & ~s2_q & {(2*N_CH){slow_en}};
  end

  function automatic logic [CNT_W-1:0] step_duty(
    input logic [CNT_W-1:0] d,
    input logic             up,
    input logic             dn
  );
    logic [CNT_W:0] dx;
    logic [CNT_W:0] sum;
    logic [CNT_W:0] diff;
    dx        = {1'b0, d};
    sum       = dx + STEP_X;
    diff      = dx - STEP_X;
    step_duty = d;
    unique case (1'b1)
      (up && !dn): begin
        if (sum > PER_X) step_duty = PER_C;
        else             step_duty = sum[CNT_W-1:0];
      end
      (dn && !up): begin
        if (dx >= STEP_X) step_duty = diff[CNT_W-1:0];
        else              step_duty = '0;
      end
      default: step_duty = d;
    endcase
  endfunction

  // Pending duty registers
  logic [CNT_W-1:0] duty_q [N_CH];
  logic [CNT_W-1:0] duty_d [N_CH];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      duty_d[i] = step_duty(duty_q[i], press[i], press[N_CH+i]);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_duty_o
    assign duty_o[g*CNT_W +: CNT_W] = duty_q[g];
  end

  // Period sequencer; ST_LOAD forces a boundary right after reset
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             mode_act_q;
  logic             mode_act_d;
  logic             bound;
  logic             ps_q;
  logic             ps_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bound   = 1'b0;
    unique case (state_q)
      ST_LOAD: bound = 1'b1;
      ST_UP: begin
        if (cnt_q == CNT_LAST) begin
          if (mode_act_q) state_d = ST_DOWN;
          else            bound   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DOWN: begin
        if (cnt_q == '0) bound = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: bound = 1'b1;
    endcase
    if (bound) begin
      state_d = ST_UP;
      cnt_d   = '0;
    end
    ps_d       = bound;
    mode_act_d = bound ? mode : mode_act_q;
  end

  // Active duty and registered compare
  logic [CNT_W-1:0] act_q [N_CH];
  logic [CNT_W-1:0] act_d [N_CH];
  logic [N_CH-1:0]  pwm_q;
  logic [N_CH-1:0]  pwm_d;
  logic [CNT_W:0]   cnt_x;

  always_comb begin
    cnt_x = {1'b0, cnt_q};
    for (int i = 0; i < N_CH; i++) begin
      act_d[i] = bound ? duty_q[i] : act_q[i];
      if (mode_act_q) begin
        pwm_d[i] = (cnt_x >= (PER_X - {1'b0, act_q[i]}));
      end else begin
        pwm_d[i] = (cnt_x < {1'b0, act_q[i]});
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_q  <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      state_q    <= ST_LOAD;
      cnt_q      <= '0;
      mode_act_q <= 1'b0;
      ps_q       <= 1'b0;
      pwm_q      <= '0;
      for (int i = 0; i < N_CH; i++) begin
        duty_q[i] <= DUTY_RST;
        act_q[i]  <= DUTY_RST;
      end
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mode_act_q <= mode_act_d;
      ps_q       <= ps_d;
      pwm_q      <= pwm_d;
      for (int i = 0; i < N_CH; i++) begin
        duty_q[i] <= duty_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = ps_q;

endmodule
